mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port word RAM between instruction fetch (I) and
//   load/store (D). It grants at most one request per cycle, drives the RAM
//   command from the winner, and returns the one-cycle-later read data to
//   the port that issued the read.
//
//   Default arbitration: D has priority. I is forced to win once it has lost
//   STARVE_LIMIT consecutive cycles while requesting.
//   Define MEM_ARB_RR_EN for round-robin arbitration. The starvation counter
//   is then unused and tied to 0.
//
// Ports
//   clk_cpu, reset          clock, synchronous active-high reset
//   if_req/if_adrs          fetch request and word-aligned byte address
//   if_gnt                  fetch granted this cycle (combinational)
//   if_rvalid/if_rdata      fetch response, rdata is 0 when not valid
//   d_req/d_we/d_adrs/
//   d_wdata/d_be            load/store request
//   d_gnt                   load/store granted this cycle (combinational)
//   d_rvalid/d_rdata        load response, rdata is 0 when not valid
//   mem_en/mem_we/mem_adrs/
//   mem_wdata/mem_be        RAM command, all zero when nothing is granted
//   mem_q                   RAM read data, valid the cycle after a read
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_cpu,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_adrs,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_adrs,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_adrs,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_I = 2'd1,
    RD_D = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [3:0] starve_cnt;

`ifdef MEM_ARB_RR_EN
  // last_winner: 0 = I, 1 = D. On a conflict the other port wins.
  logic last_winner;

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!reset) begin
      if (if_req && d_req) begin
        d_gnt  = ~last_winner;
        if_gnt = last_winner;
      end else begin
        if_gnt = if_req;
        d_gnt  = d_req;
      end
    end
  end

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      last_winner <= 1'b0;
    end else if (d_gnt) begin
      last_winner <= 1'b1;
    end else if (if_gnt) begin
      last_winner <= 1'b0;
    end
  end

  assign starve_cnt = '0;
`else
  logic force_i;

  assign force_i = if_req && (starve_cnt == 4'(STARVE_LIMIT));

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!reset) begin
      d_gnt  = d_req && !force_i;
      if_gnt = if_req && !d_gnt;
    end
  end

  // Counts cycles in which I requests but D is granted. It never exceeds
  // STARVE_LIMIT, because I wins at the limit and that grant clears it.
  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      starve_cnt <= '0;
    end else if (d_gnt) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`endif

  // RAM command mux from the winner.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_adrs  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_adrs = if_adrs;
      mem_be   = '1;
    end else if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_adrs  = d_adrs;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end
  end

  // Response FSM: records which port owns the read issued on this edge.
  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = IDLE;
    if (if_gnt) begin
      state_next = RD_I;
    end else if (d_gnt && !d_we) begin
      state_next = RD_D;
    end
  end

  // Reset masks a response that is still registered, so a read in flight
  // when reset arrives is dropped and never appears.
  assign if_rvalid = (state == RD_I) && !reset;
  assign d_rvalid  = (state == RD_D) && !reset;
  assign if_rdata  = if_rvalid ? mem_q : '0;
  assign d_rdata   = d_rvalid  ? mem_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. A behavioural write-first RAM
//   provides mem_q. Inputs change on the falling edge. Grants and the RAM
//   command are checked 1 ns later, and responses are checked on the next
//   falling edge.
module tb_mem_port_arbiter;

  logic        clk_cpu = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_adrs;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_adrs;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_adrs;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_q;

  int checks   = 0;
  int failures = 0;

  always #5 clk_cpu = ~clk_cpu;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_cpu   (clk_cpu),
    .reset     (reset),
    .if_req    (if_req),
    .if_adrs   (if_adrs),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_adrs    (d_adrs),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_adrs  (mem_adrs),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_q     (mem_q)
  );

  // Write-first word RAM with 64 words, loaded with known contents on the
  // first edge.
  logic [31:0] ram [0:63];
  logic        ram_init = 1'b0;

  always @(posedge clk_cpu) begin
    logic [31:0] w;
    if (!ram_init) begin
      for (int i = 0; i < 64; i++) ram[i] = 32'h0;
      ram[0]   = 32'h11111111;
      ram[1]   = 32'h22222222;
      ram[4]   = 32'hDEADBEEF;
      ram[8]   = 32'h12345678;
      ram_init = 1'b1;
    end
    if (mem_en) begin
      w = ram[mem_adrs[7:2]];
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
        ram[mem_adrs[7:2]] = w;
      end
      mem_q <= w;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle with I fetching 0x0 and D loading 0x4. Check the grants
  // for this cycle and the responses to the previous cycle.
  task automatic step(input logic ir, input logic dr, input logic gi, input logic gd,
                      input logic vi, input logic vd);
    if_req  = ir;
    d_req   = dr;
    if_adrs = 32'h0;
    d_adrs  = 32'h4;
    d_we    = 1'b0;
    d_be    = 4'h0;
    d_wdata = 32'h0;
    #1;
    chk("if_gnt", 32'(if_gnt), 32'(gi));
    chk("d_gnt", 32'(d_gnt), 32'(gd));
    chk("mem_en", 32'(mem_en), 32'(gi | gd));
    chk("if_rvalid", 32'(if_rvalid), 32'(vi));
    chk("d_rvalid", 32'(d_rvalid), 32'(vd));
    chk("if_rdata", if_rdata, vi ? 32'h11111111 : 32'h0);
    chk("d_rdata", d_rdata, vd ? 32'h22222222 : 32'h0);
    @(negedge clk_cpu);
  endtask

  logic [5:0] pat;  // bit k = 1 means D wins cycle k of the conflict run

  initial begin
`ifdef MEM_ARB_RR_EN
    pat = 6'b010101;
`else
    pat = 6'b101111;
`endif
    reset = 1'b1; if_req = 1'b1; d_req = 1'b1; if_adrs = 32'h0;
    d_adrs = 32'h4; d_we = 1'b0; d_be = 4'h0; d_wdata = 32'h0;

    // Reset is held for 2 cycles while both ports request.
    repeat (2) begin
      @(negedge clk_cpu);
      chk("rst_if_gnt", 32'(if_gnt), 32'h0);
      chk("rst_d_gnt", 32'(d_gnt), 32'h0);
      chk("rst_mem_en", 32'(mem_en), 32'h0);
      chk("rst_if_rvalid", 32'(if_rvalid), 32'h0);
      chk("rst_d_rvalid", 32'(d_rvalid), 32'h0);
    end

    // Single fetch from 0x10.
    reset = 1'b0; d_req = 1'b0; if_req = 1'b1; if_adrs = 32'h10;
    #1;
    chk("f_if_gnt", 32'(if_gnt), 32'h1);
    chk("f_mem_adrs", mem_adrs, 32'h10);
    chk("f_mem_we", 32'(mem_we), 32'h0);
    chk("f_mem_be", 32'(mem_be), 32'hF);
    @(negedge clk_cpu);
    if_req = 1'b0;
    #1;
    chk("f_if_rvalid", 32'(if_rvalid), 32'h1);
    chk("f_if_rdata", if_rdata, 32'hDEADBEEF);
    chk("f_d_rvalid", 32'(d_rvalid), 32'h0);
    chk("idle_mem_en", 32'(mem_en), 32'h0);
    chk("idle_mem_adrs", mem_adrs, 32'h0);
    @(negedge clk_cpu);

    // Both ports request continuously. Check the grant order and the
    // no-bubble response routing.
    for (int k = 0; k < 6; k++)
      step(1'b1, 1'b1, ~pat[k], pat[k],
           (k > 0) && !pat[(k > 0) ? k - 1 : 0], (k > 0) && pat[(k > 0) ? k - 1 : 0]);
    step(1'b0, 1'b0, 1'b0, 1'b0, ~pat[5], pat[5]);

    // Alternating single-port reads.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Partial store to 0x20, then a load from the same word.
    d_req = 1'b1; d_we = 1'b1; d_adrs = 32'h20; d_be = 4'b0011; d_wdata = 32'h0000ABCD;
    #1;
    chk("st_d_gnt", 32'(d_gnt), 32'h1);
    chk("st_mem_we", 32'(mem_we), 32'h1);
    chk("st_mem_be", 32'(mem_be), 32'h3);
    chk("st_mem_wdata", mem_wdata, 32'h0000ABCD);
    chk("st_mem_adrs", mem_adrs, 32'h20);
    @(negedge clk_cpu);
    d_we = 1'b0; d_be = 4'h0; d_wdata = 32'h0;
    #1;
    chk("ld_mem_we", 32'(mem_we), 32'h0);
    chk("st_no_rvalid", 32'(d_rvalid), 32'h0);
    @(negedge clk_cpu);
    d_req = 1'b0;
    #1;
    chk("ld_d_rvalid", 32'(d_rvalid), 32'h1);
    chk("ld_d_rdata", d_rdata, 32'h1234ABCD);
    @(negedge clk_cpu);

    // Reset arrives while a D read is outstanding.
    d_req = 1'b1; d_adrs = 32'h4;
    #1;
    chk("rr_d_gnt", 32'(d_gnt), 32'h1);
    @(negedge clk_cpu);
    d_req = 1'b0; reset = 1'b1;
    #1;
    chk("rr_d_rvalid_in_rst", 32'(d_rvalid), 32'h0);
    chk("rr_d_rdata_in_rst", d_rdata, 32'h0);
    @(negedge clk_cpu);
    reset = 1'b0;
    #1;
    chk("rr_d_rvalid_after", 32'(d_rvalid), 32'h0);
    chk("rr_if_rvalid_after", 32'(if_rvalid), 32'h0);
    @(negedge clk_cpu);
    chk("rr_d_rvalid_later", 32'(d_rvalid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
